// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks a 32-word program memory, holds each fetched
// word in an instruction register until the decoder accepts it, and supports
// single-cycle PC redirects.
// Optional feature: define IFETCH_HALT_AT_END_EN to stop fetching after the
// word at address 31 has been consumed (HALT state, halted=1).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | not fetching; waits for fetch_en
// ADDR    | rom_cs high, address presented, memory settling
// CAPTURE | rom_cs high, rom_data latched into instr on this edge
// VALID   | instr presented, waiting for instr_ready handshake
// HALT    | end of memory reached (only with IFETCH_HALT_AT_END_EN)
module instruction_fetch #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        jump_en,
  input  logic [4:0]  jump_addr,
  input  logic        instr_ready,
  input  logic [31:0] rom_data,
  output logic [4:0]  rom_addr,
  output logic        rom_cs,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [4:0]  pc,
  output logic        halted
);

`ifdef IFETCH_HALT_AT_END_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CAPTURE, S_VALID, S_HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_CAPTURE, S_VALID
  } state_t;
`endif

  state_t state;

  // Memory always sees the current PC; rom_cs qualifies it.
  assign rom_addr = pc;

`ifdef IFETCH_HALT_AT_END_EN
  logic halted_q;
  logic end_hit;   // the held instruction came from address 31
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Fetch sequencer: state, PC, instruction register and registered rom_cs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      rom_cs      <= 1'b0;
`ifdef IFETCH_HALT_AT_END_EN
      halted_q    <= 1'b0;
      end_hit     <= 1'b0;
`endif
    end else if (jump_en) begin
      // A redirect wins over everything, including a pending handshake;
      // any held or in-flight instruction is dropped.
      pc          <= jump_addr;
      instr_valid <= 1'b0;
      rom_cs      <= fetch_en;
      state       <= fetch_en ? S_ADDR : S_IDLE;
`ifdef IFETCH_HALT_AT_END_EN
      halted_q    <= 1'b0;
      end_hit     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en) begin
            state  <= S_ADDR;
            rom_cs <= 1'b1;
          end
        end
        S_ADDR: begin
          state  <= S_CAPTURE;
          rom_cs <= 1'b1;
        end
        S_CAPTURE: begin
          instr       <= rom_data;
          pc          <= pc + 5'd1;
          instr_valid <= 1'b1;
          rom_cs      <= 1'b0;
          state       <= S_VALID;
`ifdef IFETCH_HALT_AT_END_EN
          end_hit     <= (pc == 5'd31);
`endif
        end
        S_VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
`ifdef IFETCH_HALT_AT_END_EN
            if (end_hit) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
              pc       <= 5'd0;
              end_hit  <= 1'b0;
              rom_cs   <= 1'b0;
            end else
`endif
            if (fetch_en) begin
              state  <= S_ADDR;
              rom_cs <= 1'b1;
            end else begin
              state  <= S_IDLE;
              rom_cs <= 1'b0;
            end
          end
        end
`ifdef IFETCH_HALT_AT_END_EN
        S_HALT: begin
          rom_cs <= 1'b0;
        end
`endif
        default: begin
          state  <= S_IDLE;
          rom_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Program memory is modelled as
// word[i] = 32'hA000_0000 + i, driven combinationally from rom_addr.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic        instr_ready;
  logic [31:0] rom_data;
  logic [4:0]  rom_addr;
  logic        rom_cs;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_fetch #(.RESET_PC(5'd0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_en    (fetch_en),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr_ready (instr_ready),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .rom_cs      (rom_cs),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign rom_data = 32'hA000_0000 + {27'd0, rom_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    fetch_en    = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 5'd0;
    instr_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fetch_en = 1'b1; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = 5'd9;
    tick();
    tick();
    n_cmp++; if (pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 5'd0); end
    n_cmp++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, 5'd0); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_stream();
    logic [8:0]  exp_cs    = 9'b011_011_011;
    logic [8:0]  exp_valid = 9'b100_100_100;
    logic [31:0] exp_instr;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if (rom_cs !== exp_cs[i]) begin n_fail++; $display("FAIL stream_rom_cs[%0d]: got %b expected %b", i, rom_cs, exp_cs[i]); end
      n_cmp++; if (instr_valid !== exp_valid[i]) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, instr_valid, exp_valid[i]); end
      if (exp_valid[i]) begin
        exp_instr = 32'hA000_0000 + 32'(i / 3);
        n_cmp++; if (instr !== exp_instr) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, instr, exp_instr); end
        n_cmp++; if (pc !== 5'(i / 3 + 1)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0d expected %0d", i, pc, i / 3 + 1); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (instr !== 32'hA000_0000) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, instr, 32'hA000_0000); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
      n_cmp++; if (pc !== 5'd1) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0d expected 1", i, pc); end
      n_cmp++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL stall_rom_cs[%0d]: got %b expected 0", i, rom_cs); end
    end
    instr_ready = 1'b1;
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (rom_cs !== 1'b1) begin n_fail++; $display("FAIL stall_release_rom_cs: got %b expected 1", rom_cs); end
  endtask

  task automatic test_jump();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (11) tick();
    n_cmp++; if (rom_cs !== 1'b1 || pc !== 5'd3) begin n_fail++; $display("FAIL jump_pre_capture: got cs=%b pc=%0d expected cs=1 pc=3", rom_cs, pc); end
    jump_en = 1'b1; jump_addr = 5'd20;
    tick();
    jump_en = 1'b0;
    n_cmp++; if (pc !== 5'd20) begin n_fail++; $display("FAIL jump_pc: got %0d expected 20", pc); end
    n_cmp++; if (instr !== 32'hA000_0002) begin n_fail++; $display("FAIL jump_instr_kept: got %h expected %h", instr, 32'hA000_0002); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_valid: got %b expected 0", instr_valid); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_capture_valid: got %b expected 0", instr_valid); end
    tick();
    n_cmp++; if (instr !== 32'hA000_0014 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL jump_target_instr: got %h/%b expected %h/1", instr, instr_valid, 32'hA000_0014); end
    n_cmp++; if (pc !== 5'd21) begin n_fail++; $display("FAIL jump_target_pc: got %0d expected 21", pc); end
  endtask

  // Continues from test_jump: sitting in VALID with instr_ready=1.
  task automatic test_jump_priority();
    jump_en = 1'b1; jump_addr = 5'd7;
    tick();
    jump_en = 1'b0;
    n_cmp++; if (pc !== 5'd7 || instr_valid !== 1'b0 || rom_cs !== 1'b1) begin n_fail++; $display("FAIL prio_jump: got pc=%0d v=%b cs=%b expected pc=7 v=0 cs=1", pc, instr_valid, rom_cs); end
    tick();
    tick();
    n_cmp++; if (instr !== 32'hA000_0007 || pc !== 5'd8) begin n_fail++; $display("FAIL prio_fetch: got %h pc=%0d expected %h pc=8", instr, pc, 32'hA000_0007); end
  endtask

  task automatic test_fetch_drop();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    n_cmp++; if (rom_cs !== 1'b1) begin n_fail++; $display("FAIL drop_capture_cs: got %b expected 1", rom_cs); end
    tick();
    n_cmp++; if (instr !== 32'hA000_0000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL drop_presented: got %h/%b expected %h/1", instr, instr_valid, 32'hA000_0000); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0 || rom_cs !== 1'b0 || pc !== 5'd1) begin n_fail++; $display("FAIL drop_idle: got v=%b cs=%b pc=%0d expected v=0 cs=0 pc=1", instr_valid, rom_cs, pc); end
    tick();
    n_cmp++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL drop_stays_idle: got %b expected 0", rom_cs); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 5'd30;
    tick();
    jump_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (instr !== 32'hA000_001E || pc !== 5'd31) begin n_fail++; $display("FAIL wrap_w30: got %h pc=%0d expected %h pc=31", instr, pc, 32'hA000_001E); end
    repeat (3) tick();
    n_cmp++; if (instr !== 32'hA000_001F || pc !== 5'd0) begin n_fail++; $display("FAIL wrap_w31: got %h pc=%0d expected %h pc=0", instr, pc, 32'hA000_001F); end
`ifdef IFETCH_HALT_AT_END_EN
    tick();
    n_cmp++; if (halted !== 1'b1 || rom_cs !== 1'b0 || pc !== 5'd0) begin n_fail++; $display("FAIL halt_enter: got h=%b cs=%b pc=%0d expected h=1 cs=0 pc=0", halted, rom_cs, pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (halted !== 1'b1 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL halt_hold[%0d]: got h=%b cs=%b expected h=1 cs=0", i, halted, rom_cs); end
    end
    jump_en = 1'b1; jump_addr = 5'd2;
    tick();
    jump_en = 1'b0;
    n_cmp++; if (halted !== 1'b0 || pc !== 5'd2 || rom_cs !== 1'b1) begin n_fail++; $display("FAIL halt_exit: got h=%b pc=%0d cs=%b expected h=0 pc=2 cs=1", halted, pc, rom_cs); end
    tick();
    tick();
    n_cmp++; if (instr !== 32'hA000_0002 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL halt_refetch: got %h/%b expected %h/1", instr, instr_valid, 32'hA000_0002); end
`else
    repeat (3) tick();
    n_cmp++; if (instr !== 32'hA000_0000 || pc !== 5'd1) begin n_fail++; $display("FAIL wrap_w0: got %h pc=%0d expected %h pc=1", instr, pc, 32'hA000_0000); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b expected 0", halted); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (rom_cs !== 1'b1 || pc !== 5'd1) begin n_fail++; $display("FAIL areset_pre: got cs=%b pc=%0d expected cs=1 pc=1", rom_cs, pc); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 5'd0 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL areset_now: got pc=%0d cs=%b expected pc=0 cs=0", pc, rom_cs); end
    n_cmp++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_instr: got %h/%b expected 0/0", instr, instr_valid); end
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (instr !== 32'hA000_0000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL areset_refetch: got %h/%b expected %h/1", instr, instr_valid, 32'hA000_0000); end
  endtask

  initial begin
    reset_n = 1'b0; fetch_en = 1'b0; jump_en = 1'b0; jump_addr = 5'd0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_priority();
    test_fetch_drop();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 5'd0, giving the program counter value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port fetch_en, input, 1 bit: when 1, fetching is permitted; when 0, the block idles after the current instruction is consumed.
REQ-005 The block SHALL have port jump_en, input, 1 bit: a one-cycle request to redirect the PC.
REQ-006 The block SHALL have port jump_addr, input, 5 bits: the redirect target, sampled when jump_en=1.
REQ-007 The block SHALL have port instr_ready, input, 1 bit: the decoder accepts instr when instr_valid=1 and instr_ready=1.
REQ-008 The block SHALL have port rom_data, input, 32 bits: the instruction word returned by program memory.
REQ-009 The block SHALL have port rom_addr, output, 5 bits: the program memory word address, always equal to pc.
REQ-010 The block SHALL have port rom_cs, output, 1 bit: the program memory chip select.
REQ-011 The block SHALL have port instr, output, 32 bits: the latched instruction register.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr holds an unconsumed instruction.
REQ-013 The block SHALL have port pc, output, 5 bits: the address of the next word to fetch.
REQ-014 The block SHALL have port halted, output, 1 bit: fetch has stopped at end of memory (see Configuration).

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR, CAPTURE, VALID and HALT, one-hot or binary.
REQ-016 In IDLE, the block SHALL move to ADDR when fetch_en=1 and SHALL stay in IDLE otherwise.
REQ-017 In ADDR, rom_cs SHALL be 1 and rom_addr SHALL be pc, giving memory one full cycle to settle, and the block SHALL then move unconditionally to CAPTURE.
REQ-018 In CAPTURE, rom_cs SHALL be 1, and on the edge the block SHALL perform instr<=rom_data, pc<=pc+1 (5-bit, 31 wraps to 0), instr_valid<=1, and move to VALID.
REQ-019 rom_cs SHALL be 0 in every state other than ADDR and CAPTURE.
REQ-020 In VALID, instr and instr_valid SHALL be held stable until instr_ready=1; on that handshake the block SHALL clear instr_valid and go to ADDR if fetch_en=1, else to IDLE.
REQ-021 Latency: the first instr_valid=1 SHALL appear 2 cycles after the state leaves IDLE; steady-state throughput SHALL be one instruction per 3 cycles with instr_ready held at 1.
REQ-022 A jump (jump_en=1) in any state except HALT SHALL load pc<=jump_addr, clear instr_valid and move to ADDR if fetch_en=1, else to IDLE; CAPTURE's pc increment and instr load SHALL be suppressed that cycle.
REQ-023 A jump SHALL take priority over a simultaneous instr_ready handshake in VALID; the held instruction counts as consumed.
REQ-024 Dropping fetch_en SHALL NOT abort an ADDR/CAPTURE sequence in progress; the instruction SHALL still be captured and presented.
REQ-025 instr SHALL NOT change while instr_valid=1 except through reset.

Reset
REQ-026 While reset_n=0, the block SHALL force immediately, regardless of clk, state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, halted=0 and rom_cs=0.
REQ-027 Reset asserted mid-fetch SHALL discard the in-flight instruction; after release, the first fetch SHALL be from RESET_PC.

Configuration
REQ-028 With the macro IFETCH_HALT_AT_END_EN defined, the block SHALL, on a CAPTURE from pc=31, present the instruction normally, and after its handshake SHALL enter HALT (rom_cs=0, halted=1, pc=0) instead of ADDR or IDLE.
REQ-029 HALT SHALL be left only by reset or by jump_en=1, which loads jump_addr, clears halted and proceeds as in REQ-022.
REQ-030 Without IFETCH_HALT_AT_END_EN, the HALT state SHALL be absent, halted SHALL be tied to 0, and the PC SHALL wrap from 31 to 0 with fetching continuing.

Verification
REQ-031 Reset, fetch_en=1, instr_ready=1, ROM word[i]=32'hA000_0000+i -> instr sequence A0000000, A0000001, A0000002 with instr_valid pulses every 3 cycles, rom_cs high 2 of every 3 cycles.
REQ-032 instr_ready=0 for 10 cycles after the first valid -> instr stays A0000000, pc stays 1, and rom_cs stays 0 throughout.
REQ-033 jump_en=1 with jump_addr=5'd20 during CAPTURE of address 3 -> no instr for address 3, next valid instr=A0000014, then pc=21.
REQ-034 Start at pc=30 with instr_ready=1 -> words 30 and 31 are fetched; without the macro the next word is word 0; with the macro halted=1, rom_cs stays 0, and a later jump to 2 fetches word 2.
REQ-035 reset_n asserted between clock edges during ADDR -> outputs reset asynchronously, and after release the first fetched instr is word RESET_PC.
